// File: rtl/vram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vram_pkg
// Purpose  : Shared frame-buffer geometry, defaults and types for the VRAM arbiter.
// Revision : 1.0
// ============================================================================
package vram_pkg;

  localparam int VRAM_ADDR_W = 14;
  localparam int VRAM_DATA_W = 3;
  localparam int FB_W        = 128;
  localparam int FB_H        = 96;
  localparam int FB_PIXELS   = FB_W * FB_H;

  typedef enum logic [0:0] {
    S_NORM  = 1'b0,
    S_FORCE = 1'b1
  } state_t;

  typedef logic [VRAM_DATA_W-1:0] pixel_t;

endpackage
`default_nettype wire

// File: rtl/vram_wr_fifo.sv
`default_nettype none
// ============================================================================
// Module   : vram_wr_fifo
// Purpose  : Synchronous write-buffer FIFO; head is presented combinationally.
// Revision : 1.0
// ============================================================================
module vram_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] C_FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == C_FULL);
  assign empty  = (r_count == '0);
  // A full FIFO refuses pushes even when the same cycle pops.
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign head   = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Purpose  : Single-port frame-buffer arbiter: scanout reads win, buffered
//            writes drain in idle slots, starvation guard forces a write.
//            Optional stall statistics under macro VRAM_ARB_STATS_EN.
// Revision : 1.0
// ============================================================================
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W       = VRAM_ADDR_W,
  parameter int DATA_W       = VRAM_DATA_W,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              fifo_empty,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STARVE_LIMIT);

  state_t                   r_state;
  logic [CNT_W-1:0]         r_starve_cnt;
  logic [CNT_W-1:0]         w_starve_nxt;
  logic                     r_rd_pend;
  logic                     r_rd_valid;
  logic [DATA_W-1:0]        r_rd_data;
  logic                     w_rd_gnt;
  logic                     w_wr_gnt;
  logic                     w_full;
  logic                     w_empty;
  logic [ADDR_W+DATA_W-1:0] w_head;
  logic [ADDR_W-1:0]        w_head_addr;
  logic [DATA_W-1:0]        w_head_data;

  vram_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_wr_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_valid),
    .push_data ({wr_addr, wr_data}),
    .pop       (w_wr_gnt),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign {w_head_addr, w_head_data} = w_head;

  // Grants are held off while reset is asserted so the RAM sees no access.
  always_comb begin
    w_rd_gnt = 1'b0;
    w_wr_gnt = 1'b0;
    if (reset) begin
      if (r_state == S_FORCE) w_wr_gnt = !w_empty;
      else if (rd_req)        w_rd_gnt = 1'b1;
      else                    w_wr_gnt = !w_empty;
    end
  end

  assign rd_gnt     = w_rd_gnt;
  assign mem_en     = w_rd_gnt | w_wr_gnt;
  assign mem_we     = w_wr_gnt;
  assign mem_addr   = w_wr_gnt ? w_head_addr : (w_rd_gnt ? rd_addr : '0);
  assign mem_wdata  = w_wr_gnt ? w_head_data : '0;
  assign wr_ready   = !w_full;
  assign fifo_empty = w_empty;
  assign rd_valid   = r_rd_valid;
  assign rd_data    = r_rd_data;

  always_comb begin
    if (w_empty || w_wr_gnt)        w_starve_nxt = '0;
    else if (r_starve_cnt == C_LIMIT) w_starve_nxt = r_starve_cnt;
    else                            w_starve_nxt = r_starve_cnt + 1'b1;
  end

  // Entering S_FORCE when the count reaches the limit puts the forced write
  // in the cycle right after the last starved one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_NORM;
      r_starve_cnt <= '0;
    end else begin
      r_starve_cnt <= w_starve_nxt;
      case (r_state)
        S_NORM:
          if (rd_req && !w_empty && (w_starve_nxt == C_LIMIT)) r_state <= S_FORCE;
        S_FORCE: r_state <= S_NORM;
        default: r_state <= S_NORM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_pend  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_pend  <= w_rd_gnt;
      r_rd_valid <= r_rd_pend;
      if (r_rd_pend) r_rd_data <= mem_rdata;
    end
  end

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_FORCE) && rd_req && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire
